// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// address-field width helpers and tag/index/word extraction functions.
package icache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - 2 - $clog2(line_words) - $clog2(lines);
    endfunction

    // Extraction works on a zero-extended 64-bit address; callers size-cast the result.
    function automatic logic [63:0] get_word(input logic [63:0] a, input int line_words);
        return (a >> 2) & (64'(line_words) - 64'd1);
    endfunction

    function automatic logic [63:0] get_idx(input logic [63:0] a, input int lines, input int line_words);
        return (a >> (2 + $clog2(line_words))) & (64'(lines) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] a, input int lines, input int line_words);
        return a >> (2 + $clog2(line_words) + $clog2(lines));
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one synchronous write port, one asynchronous read port.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_W, LINES, LINE_WORDS);
    localparam int RAM_AW = OFF_W + IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [LINES-1:0]  line_vld_q, line_vld_d;
    logic [TAG_W-1:0]  tag_arr [LINES];
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [OFF_W-1:0]  req_word_q;

    logic [63:0]       addr_x;
    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_word;
    logic [ADDR_W-1:0] line_base;
    logic              accept;
    logic              hit;
    logic              tag_we;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_raddr;
    logic [WORD_W-1:0] ram_rdata;

    assign addr_x    = 64'(addr);
    assign a_tag     = TAG_W'(get_tag(addr_x, LINES, LINE_WORDS));
    assign a_idx     = IDX_W'(get_idx(addr_x, LINES, LINE_WORDS));
    assign a_word    = OFF_W'(get_word(addr_x, LINE_WORDS));
    assign line_base = {addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};

    // A flush in the same cycle as a lookup forces a miss.
    assign accept = (state_q == IDLE) && ena;
    assign hit    = line_vld_q[a_idx] && (tag_arr[a_idx] == a_tag) && !flush;

    // During refill the read port serves the latched requested word.
    assign ram_raddr = (state_q == REFILL) ? {req_idx_q, req_word_q} : {a_idx, a_word};

    icache_data_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({req_idx_q, cnt_q}),
        .wdata (mem_rdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        line_vld_d = line_vld_q;
        valid_d    = valid_q;
        data_d     = data_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        tag_we     = 1'b0;
        ram_we     = 1'b0;

        if (flush) begin
            line_vld_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (ena) begin
                    if (hit) begin
                        valid_d = 1'b1;
                        data_d  = ram_rdata;
                    end else begin
                        valid_d    = 1'b0;
                        state_d    = REFILL;
                        mem_req_d  = 1'b1;
                        mem_addr_d = line_base;
                        cnt_d      = '0;
                        kill_d     = 1'b0;
                    end
                end
            end
            REFILL: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_ack && mem_req_q) begin
                    ram_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        // A flush seen at any point of the refill leaves the line invalid.
                        tag_we = 1'b1;
                        if (!kill_q && !flush) begin
                            line_vld_d[req_idx_q] = 1'b1;
                        end
                        mem_req_d = 1'b0;
                        valid_d   = 1'b1;
                        data_d    = (req_word_q == cnt_q) ? mem_rdata : ram_rdata;
                        state_d   = IDLE;
                    end else begin
                        cnt_d      = cnt_q + OFF_W'(1);
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            line_vld_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_vld_q <= line_vld_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            req_tag_q  <= a_tag;
            req_idx_q  <= a_idx;
            req_word_q <= a_word;
        end
        if (tag_we) begin
            tag_arr[req_idx_q] <= req_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

    assign valid    = valid_q;
    assign data     = data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a line-granular reference model predicts hit/miss,
// returned word and latency; a memory responder returns word = address.
module tb_icache_dm;

    localparam int LINES = 16;
    localparam int LW    = 4;
    localparam int OFFB  = $clog2(LW) + 2;
    localparam int IDXB  = $clog2(LINES);

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        valid;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [31:0] mtag [int];
    int          m_hit = 0;
    int          m_miss = 0;
    int          stall_n = 0;
    int          wcnt = 0;
    int          ack_k = 0;
    bit          refill_exp = 1'b0;
    logic [31:0] exp_base = '0;

    icache_dm dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .addr      (addr),
        .flush     (flush),
        .valid     (valid),
        .data      (data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: acks after stall_n low cycles, sprinkles stray acks while idle.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else begin
            check("mem_req", 32'(mem_req), 32'(refill_exp));
            if (mem_req) begin
                check("mem_addr", mem_addr, exp_base + 32'(4 * ack_k));
                if (wcnt >= stall_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr;
                    wcnt = 0;
                    ack_k++;
                    if (ack_k == LW) refill_exp = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
                wcnt = 0;
            end
        end
    end

    // Monitor: each presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("data", data, e.data);
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
    end

    task automatic fetch(input logic [31:0] a, input int stall, input bit fl_with, input bit fl_mid);
        int   idx;
        logic [31:0] tag;
        bit   hit;
        bit   killed;
        exp_t e;
        idx = int'((a >> OFFB) % LINES);
        tag = a >> (OFFB + IDXB);
        if (fl_with) mtag.delete();
        hit = mtag.exists(idx) && (mtag[idx] == tag);
        stall_n = stall;
        @(negedge clk);
        ena = 1'b1;
        addr = a;
        flush = fl_with;
        e.data = a & ~32'h3;
        e.acc  = cyc;
        e.lat  = hit ? 1 : LW * (stall + 1) + 1;
        @(posedge clk);
        sb.push_back(e);
        if (hit) begin
            m_hit++;
        end else begin
            m_miss++;
            exp_base = a & ~32'((1 << OFFB) - 1);
            ack_k = 0;
            refill_exp = 1'b1;
        end
        #1;
        ena = 1'b0;
        flush = 1'b0;
        addr = $urandom;
        killed = 1'b0;
        if (fl_mid && !hit) begin
            @(negedge clk);
            flush = 1'b1;
            mtag.delete();
            @(posedge clk);
            #1 flush = 1'b0;
            killed = 1'b1;
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: %0d responses outstanding for addr %h, expected 0", sb.size(), a);
            sb.delete();
            refill_exp = 1'b0;
        end
        if (!hit && !killed) mtag[idx] = tag;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        mtag.delete();
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic idle_hold(input int n);
        logic [31:0] d0;
        @(negedge clk);
        d0 = data;
        repeat (n) @(negedge clk);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", data, d0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Cold miss, then hit in the same line, then conflicting tag on index 0.
        fetch(32'h0040_0004, 0, 1'b0, 1'b0);
        fetch(32'h0040_000C, 0, 1'b0, 1'b0);
        fetch(32'h0040_0100, 0, 1'b0, 1'b0);
        fetch(32'h0040_0000, 0, 1'b0, 1'b0);
        idle_hold(3);

        // Slow memory: three idle cycles before every ack.
        fetch(32'h0040_0208, 3, 1'b0, 1'b0);
        fetch(32'h0040_0204, 0, 1'b0, 1'b0);

        // Reset abandons a refill after two acks.
        stall_n = 0;
        @(negedge clk);
        ena = 1'b1;
        addr = 32'h0040_0310;
        @(posedge clk);
        exp_base = 32'h0040_0310;
        ack_k = 0;
        refill_exp = 1'b1;
        #1 ena = 1'b0;
        for (int i = 0; i < 50 && ack_k < 2; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        refill_exp = 1'b0;
        sb.delete();
        mtag.delete();
        m_hit = 0;
        m_miss = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_valid", 32'(valid), 32'd0);
        fetch(32'h0040_0000, 0, 1'b0, 1'b0);

        // Flush between hits; flush with ena; flush during refill.
        fetch(32'h0040_0000, 0, 1'b0, 1'b0);
        do_flush();
        fetch(32'h0040_0000, 0, 1'b0, 1'b0);
        fetch(32'h0040_0008, 0, 1'b1, 1'b0);
        fetch(32'h0040_0414, 1, 1'b0, 1'b1);
        fetch(32'h0040_0418, 0, 1'b0, 1'b0);
        fetch(32'h0040_041C, 0, 1'b0, 1'b0);
`ifdef ICACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'(m_hit));
        check("miss_cnt", miss_cnt, 32'(m_miss));
`endif

        for (int n = 0; n < 250; n++) begin
            a = 32'h0040_0000 | (32'($urandom_range(0, 2)) << 8) | 32'($urandom_range(0, 255));
            fetch(a, $urandom_range(0, 2), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 7) == 0) idle_hold($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) do_flush();
        end
`ifdef ICACHE_STATS_EN
        check("hit_cnt_end", hit_cnt, 32'(m_hit));
        check("miss_cnt_end", miss_cnt, 32'(m_miss));
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
